// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: blink / alternate / chase / bounce, stepped by a divided tick.
// Optional brightness dimmer enabled by defining LED_PWM_DIM_EN.
module led_pattern_ctrl #(
   parameter int CLK_HZ  = 12000000,
   parameter int TICK_HZ = 2,
   parameter int N_LED   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic [3:0]       brightness,
   output logic [N_LED-1:0] led,
   output logic             tick
);

   // state      | meaning
   // MODE_BLINK | all LEDs follow phase
   // MODE_ALT   | even LEDs = phase, odd LEDs = ~phase
   // MODE_CHASE | one-hot at pos, pos wraps upward
   // MODE_BOUNCE| one-hot at pos, pos reflects at both ends
   typedef enum logic [1:0] {
      MODE_BLINK  = 2'd0,
      MODE_ALT    = 2'd1,
      MODE_CHASE  = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_t;

   localparam int DIV      = CLK_HZ / TICK_HZ;
   localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW       = (N_LED > 1) ? $clog2(N_LED) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 1);
   localparam logic [PW-1:0] POS_PEN  = PW'((N_LED > 1) ? (N_LED - 2) : 0);
   localparam logic [PW-1:0] POS_ONE  = PW'((N_LED > 1) ? 1 : 0);

   if (DIV < 2) begin : g_bad_div
      $error("led_pattern_ctrl: CLK_HZ/TICK_HZ must be at least 2");
   end
   if (N_LED < 1 || N_LED > 32) begin : g_bad_nled
      $error("led_pattern_ctrl: N_LED must be within 1..32");
   end

   logic [CW-1:0]    r_cnt;
   logic             r_tick;
   mode_t            r_mode_q;
   logic             r_phase;
   logic [PW-1:0]    r_pos;
   logic             r_dir;
   logic [N_LED-1:0] w_pattern;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         r_tick <= (r_cnt == CNT_LAST);
      end
   end

   assign tick = r_tick;

   // A differing mode request only reloads; stepping resumes on the following tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode_q <= MODE_BLINK;
         r_phase  <= 1'b0;
         r_pos    <= '0;
         r_dir    <= 1'b0;
      end else if (r_tick) begin
         if (mode != r_mode_q) begin
            r_mode_q <= mode_t'(mode);
            r_phase  <= 1'b0;
            r_pos    <= '0;
            r_dir    <= 1'b0;
         end else begin
            r_phase <= ~r_phase;
            case (r_mode_q)
               MODE_CHASE: begin
                  r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
               end
               MODE_BOUNCE: begin
                  if (N_LED == 1) begin
                     r_pos <= '0;
                  end else if (!r_dir) begin
                     if (r_pos == POS_LAST) begin
                        r_dir <= 1'b1;
                        r_pos <= POS_PEN;
                     end else begin
                        r_pos <= r_pos + 1'b1;
                     end
                  end else begin
                     if (r_pos == '0) begin
                        r_dir <= 1'b0;
                        r_pos <= POS_ONE;
                     end else begin
                        r_pos <= r_pos - 1'b1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   always_comb begin
      w_pattern = '0;
      case (r_mode_q)
         MODE_BLINK: w_pattern = {N_LED{r_phase}};
         MODE_ALT: begin
            for (int i = 0; i < N_LED; i++) begin
               w_pattern[i] = (i % 2 == 0) ? r_phase : ~r_phase;
            end
         end
         default: begin
            for (int i = 0; i < N_LED; i++) begin
               w_pattern[i] = (r_pos == PW'(i));
            end
         end
      endcase
   end

`ifdef LED_PWM_DIM_EN
   logic [3:0] r_pwm_cnt;
   logic       w_pwm_on;

   // 15-slot period so brightness 15 is fully on and 0 fully off.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= (r_pwm_cnt == 4'd14) ? 4'd0 : r_pwm_cnt + 4'd1;
      end
   end

   assign w_pwm_on = (r_pwm_cnt < brightness);
   assign led      = w_pattern & {N_LED{w_pwm_on}};
`else
   logic w_unused_brightness;

   assign w_unused_brightness = ^brightness;
   assign led                 = w_pattern;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl at CLK_HZ=20, TICK_HZ=2 (DIV=10), N_LED=4.
module tb_led_pattern_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [3:0] brightness;
   logic [3:0] led;
   logic       tick;

   int total = 0;
   int bad   = 0;

   led_pattern_ctrl #(.CLK_HZ(20), .TICK_HZ(2), .N_LED(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .brightness (brightness),
      .led        (led),
      .tick       (tick)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns cycles until tick is seen high (gives up after 40).
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (tick !== 1'b1 && n < 40);
   endtask

   task automatic reset_dut(input logic [1:0] m);
      rst  = 1'b1;
      mode = m;
      cyc(3);
      rst  = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      rst = 1'b1; mode = 2'd0; brightness = 4'd15;
      cyc(3);
      total++; if (led !== 4'b0000) begin bad++; $display("FAIL reset_led got=%b exp=0000", led); end
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
      rst = 1'b0;
      wait_tick(n);
      total++; if (n !== 10) begin bad++; $display("FAIL first_tick_delay got=%0d exp=10", n); end
      total++; if (led !== 4'b0000) begin bad++; $display("FAIL led_on_tick got=%b exp=0000", led); end
      cyc(1);
      total++; if (led !== 4'b1111) begin bad++; $display("FAIL blink1 got=%b exp=1111", led); end
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL tick_width got=%b exp=0", tick); end
      wait_tick(n);
      total++; if (n !== 9) begin bad++; $display("FAIL second_tick_delay got=%0d exp=9", n); end
      cyc(1);
      total++; if (led !== 4'b0000) begin bad++; $display("FAIL blink2 got=%b exp=0000", led); end
      wait_tick(n);
      total++; if (n !== 9) begin bad++; $display("FAIL third_tick_delay got=%0d exp=9", n); end
      cyc(1);
      total++; if (led !== 4'b1111) begin bad++; $display("FAIL blink3 got=%b exp=1111", led); end
   endtask

   task automatic test_alternate;
      int n;
      logic [3:0] exp_seq [3] = '{4'b1010, 4'b0101, 4'b1010};
      reset_dut(2'd1);
      for (int k = 0; k < 3; k++) begin
         wait_tick(n);
         cyc(1);
         total++;
         if (led !== exp_seq[k]) begin
            bad++; $display("FAIL alt_step%0d got=%b exp=%b", k, led, exp_seq[k]);
         end
      end
   endtask

   task automatic test_bounce;
      int n;
      int pos_seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      logic [3:0] exp;
      reset_dut(2'd3);
      for (int k = 0; k < 8; k++) begin
         wait_tick(n);
         cyc(1);
         exp = 4'b0001 << pos_seq[k];
         total++;
         if (led !== exp) begin
            bad++; $display("FAIL bounce_step%0d got=%b exp=%b", k, led, exp);
         end
      end
   endtask

   task automatic test_chase_and_mid_reset;
      int n;
      reset_dut(2'd2);
      wait_tick(n); cyc(1);
      total++; if (led !== 4'b0001) begin bad++; $display("FAIL chase_load got=%b exp=0001", led); end
      wait_tick(n); cyc(1);
      total++; if (led !== 4'b0010) begin bad++; $display("FAIL chase_step1 got=%b exp=0010", led); end
      mode = 2'd0;
      cyc(1);
      total++; if (led !== 4'b0010) begin bad++; $display("FAIL chase_mode_glitch got=%b exp=0010", led); end
      cyc(2);
      mode = 2'd2;
      wait_tick(n); cyc(1);
      total++; if (led !== 4'b0100) begin bad++; $display("FAIL chase_no_reload got=%b exp=0100", led); end
      wait_tick(n); cyc(1);
      total++; if (led !== 4'b1000) begin bad++; $display("FAIL chase_pos3 got=%b exp=1000", led); end
      cyc(4);
      rst = 1'b1;
      cyc(1);
      total++; if (led !== 4'b0000) begin bad++; $display("FAIL midrst_led got=%b exp=0000", led); end
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL midrst_tick got=%b exp=0", tick); end
      rst  = 1'b0;
      mode = 2'd0;
      wait_tick(n);
      total++; if (n !== 10) begin bad++; $display("FAIL midrst_tick_delay got=%0d exp=10", n); end
      cyc(1);
      total++; if (led !== 4'b1111) begin bad++; $display("FAIL midrst_mode0 got=%b exp=1111", led); end
   endtask

   task automatic test_brightness;
      int n;
      int on_cnt;
`ifdef LED_PWM_DIM_EN
      int exp_on [3] = '{5, 0, 15};
      logic [3:0] br [3] = '{4'd5, 4'd0, 4'd15};
      reset_dut(2'd1);
      wait_tick(n); cyc(1);
      for (int k = 0; k < 3; k++) begin
         brightness = br[k];
         on_cnt = 0;
         for (int c = 0; c < 15; c++) begin
            if (led !== 4'b0000) on_cnt++;
            cyc(1);
         end
         total++;
         if (on_cnt !== exp_on[k]) begin
            bad++; $display("FAIL pwm_br%0d got=%0d exp=%0d", br[k], on_cnt, exp_on[k]);
         end
      end
`else
      reset_dut(2'd0);
      brightness = 4'd0;
      wait_tick(n); cyc(1);
      on_cnt = 0;
      for (int c = 0; c < 9; c++) begin
         if (led === 4'b1111) on_cnt++;
         if (c == 4) brightness = 4'd5;
         cyc(1);
      end
      total++;
      if (on_cnt !== 9) begin bad++; $display("FAIL br_ignored got=%0d exp=9", on_cnt); end
`endif
   endtask

   initial begin
      rst = 1'b1; mode = 2'd0; brightness = 4'd15;
      test_reset();
      test_alternate();
      test_bounce();
      test_chase_and_mid_reset();
      test_brightness();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
